// File: rtl/if_stage_pkg.sv
// ============================================================================
// if_stage_pkg
// Shared pipeline header: inter-stage bus widths and bus layouts.
// Revision: 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD       = 34;

  // Branch information returned from decode
  typedef struct packed {
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  // Fetched instruction handed to decode
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

endpackage

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage
// Pre-IF / IF pipeline front end: computes nextpc, issues instruction SRAM
// reads, buffers a late branch target and a stalled instruction word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  br_bus_t     br;
  fs_to_ds_t   fs_out;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_buf_valid_q, br_buf_valid_d;
  logic [31:0] br_buf_target_q, br_buf_target_d;

  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fs_xfer;
  logic        req_fire;
  logic [31:0] nextpc;

  assign br = br_bus;

  // The SRAM returns data one cycle after the request, and anything still held
  // afterwards lives in inst_buf, so fs is always ready once it is valid.
  assign fs_ready_go    = 1'b1;
  assign fs_allowin     = !fs_valid_q || (fs_ready_go && ds_allowin);
  assign fs_to_ds_valid = fs_valid_q && fs_ready_go;
  assign fs_xfer        = fs_to_ds_valid && ds_allowin;

  // A request is only raised when it will be accepted, so every pulse of
  // inst_sram_en corresponds to exactly one fetched PC.
  assign req_fire = resetn && fs_allowin && !br.stall;

  assign nextpc = br_buf_valid_q ? br_buf_target_q :
                  br.taken       ? br.target       :
                                   fs_pc_q + 32'd4;

  assign inst_sram_en    = req_fire;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  assign fs_out.inst  = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign fs_out.pc    = fs_pc_q;
  assign fs_to_ds_bus = fs_out;

  // Next-state for the fs slot, the stalled-instruction buffer and branch buffer
  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;
    br_buf_valid_d   = br_buf_valid_q;
    br_buf_target_d  = br_buf_target_q;

    if (req_fire) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end else if (fs_xfer) begin
      fs_valid_d = 1'b0;
    end

    // SRAM data is only live in the first cycle fs is valid; keep it if
    // decode cannot take it now.
    if (fs_xfer) begin
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q && !inst_buf_valid_q && !ds_allowin) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = inst_sram_rdata;
    end

    // A taken branch is presented for one cycle; hold its target until the
    // front end can issue it.
    if (req_fire) begin
      br_buf_valid_d = 1'b0;
    end else if (br.taken && !br.stall && !br_buf_valid_q) begin
      br_buf_valid_d  = 1'b1;
      br_buf_target_d = br.target;
    end
  end

  // State registers; reset drops any in-flight request and buffered data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0;
      br_buf_valid_q   <= 1'b0;
      br_buf_target_q  <= 32'h0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      br_buf_valid_q   <= br_buf_valid_d;
      br_buf_target_q  <= br_buf_target_d;
    end
  end

`ifndef SYNTHESIS
  // Decode must not raise a second branch while a target is still buffered
  a_no_taken_while_buffered: assert property (
    @(posedge clk) disable iff (!resetn) !(br.taken && br_buf_valid_q));
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage
// Self-checking bench for if_stage: directed vector table, reset-during-stall
// sequence, and randomized run against a program-order reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        inv_mode;

  int n_cmp;
  int n_err;

  assign br_bus = {br_stall, br_taken, br_target};

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return inv_mode ? ~a : a;
  endfunction

  // SRAM model: data valid one cycle after a request, garbage otherwise
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ds;
    logic        stall;
    logic        taken;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic ds, input logic stall, input logic taken,
                              input logic [31:0] tgt, input logic en,
                              input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc);
    vec_t v;
    v.ds = ds; v.stall = stall; v.taken = taken; v.tgt = tgt;
    v.en = en; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, settle before rising edge
  task automatic drive(input logic ds, input logic stall, input logic taken,
                       input logic [31:0] tgt);
    @(negedge clk);
    ds_allowin = ds;
    br_stall   = stall;
    br_taken   = taken;
    br_target  = tgt;
    #4;
  endtask

  vec_t tbl[23];

  // Reference model state (program-order view of the front end)
  logic [31:0] issued_q[$];
  logic [31:0] m_last;
  logic        m_pend;
  logic [31:0] m_tgt;

  initial begin
    n_cmp = 0;
    n_err = 0;
    inv_mode   = 1'b0;
    resetn     = 1'b0;
    ds_allowin = 1'b1;
    br_stall   = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;

    //            ds stall tk tgt           en addr          vld pc
    tbl[0]  = mk(1, 0, 0, 32'h0,         1, 32'hbfc00000, 0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 32'h0,         1, 32'hbfc00004, 1, 32'hbfc00000);
    tbl[2]  = mk(1, 0, 0, 32'h0,         1, 32'hbfc00008, 1, 32'hbfc00004);
    tbl[3]  = mk(1, 0, 0, 32'h0,         1, 32'hbfc0000c, 1, 32'hbfc00008);
    tbl[4]  = mk(1, 0, 0, 32'h0,         1, 32'hbfc00010, 1, 32'hbfc0000c);
    tbl[5]  = mk(1, 0, 0, 32'h0,         1, 32'hbfc00014, 1, 32'hbfc00010);
    tbl[6]  = mk(1, 0, 1, 32'hbfc00100,  1, 32'hbfc00100, 1, 32'hbfc00014);
    tbl[7]  = mk(1, 0, 0, 32'h0,         1, 32'hbfc00104, 1, 32'hbfc00100);
    tbl[8]  = mk(0, 1, 1, 32'hbfc00200,  0, 32'h0,        1, 32'hbfc00104);
    tbl[9]  = mk(0, 1, 1, 32'hbfc00200,  0, 32'h0,        1, 32'hbfc00104);
    tbl[10] = mk(0, 1, 1, 32'hbfc00200,  0, 32'h0,        1, 32'hbfc00104);
    tbl[11] = mk(1, 0, 1, 32'hbfc00200,  1, 32'hbfc00200, 1, 32'hbfc00104);
    tbl[12] = mk(1, 0, 0, 32'h0,         1, 32'hbfc00204, 1, 32'hbfc00200);
    tbl[13] = mk(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hbfc00204);
    tbl[14] = mk(0, 0, 1, 32'hbfc00300,  0, 32'h0,        1, 32'hbfc00204);
    tbl[15] = mk(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hbfc00204);
    tbl[16] = mk(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hbfc00204);
    tbl[17] = mk(1, 0, 0, 32'h0,         1, 32'hbfc00300, 1, 32'hbfc00204);
    tbl[18] = mk(1, 0, 0, 32'h0,         1, 32'hbfc00304, 1, 32'hbfc00300);
    tbl[19] = mk(1, 0, 0, 32'h0,         1, 32'hbfc00308, 1, 32'hbfc00304);
    tbl[20] = mk(1, 0, 1, 32'hfffffffc,  1, 32'hfffffffc, 1, 32'hbfc00308);
    tbl[21] = mk(1, 0, 0, 32'h0,         1, 32'h00000000, 1, 32'hfffffffc);
    tbl[22] = mk(1, 0, 0, 32'h0,         1, 32'h00000004, 1, 32'h00000000);

    // Reset state
    repeat (2) @(negedge clk);
    #4;
    chk("rst_en",    {63'h0, inst_sram_en},   64'h0);
    chk("rst_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    chk("rst_wen",   {60'h0, inst_sram_wen},  64'h0);
    chk("rst_wdata", {32'h0, inst_sram_wdata}, 64'h0);

    // Directed vector table
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 0) resetn = 1'b1;
      ds_allowin = tbl[i].ds;
      br_stall   = tbl[i].stall;
      br_taken   = tbl[i].taken;
      br_target  = tbl[i].tgt;
      #4;
      chk($sformatf("tbl%0d_en", i), {63'h0, inst_sram_en}, {63'h0, tbl[i].en});
      if (tbl[i].en)
        chk($sformatf("tbl%0d_addr", i), {32'h0, inst_sram_addr}, {32'h0, tbl[i].addr});
      chk($sformatf("tbl%0d_valid", i), {63'h0, fs_to_ds_valid}, {63'h0, tbl[i].vld});
      if (tbl[i].vld)
        chk($sformatf("tbl%0d_bus", i), fs_to_ds_bus, {inst_of(tbl[i].pc), tbl[i].pc});
    end

    // Reset pulsed while an instruction sits in inst_buf
    drive(0, 0, 0, 32'h0);
    chk("rs_hold_bus", fs_to_ds_bus, {32'h4, 32'h4});
    drive(0, 0, 0, 32'h0);
    chk("rs_buf_bus", fs_to_ds_bus, {32'h4, 32'h4});
    #1 resetn = 1'b0;
    #1;
    chk("rs_async_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    chk("rs_async_en",    {63'h0, inst_sram_en},   64'h0);
    drive(1, 0, 0, 32'h0);
    chk("rs_low_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    #4;
    chk("rs_rel_en",    {63'h0, inst_sram_en},    64'h1);
    chk("rs_rel_addr",  {32'h0, inst_sram_addr},  {32'h0, RESET_PC});
    chk("rs_rel_valid", {63'h0, fs_to_ds_valid},  64'h0);
    drive(1, 0, 0, 32'h0);
    chk("rs_2nd_addr", {32'h0, inst_sram_addr}, {32'h0, RESET_PC + 32'd4});
    chk("rs_2nd_bus",  fs_to_ds_bus, {RESET_PC, RESET_PC});

    // Randomized run against the program-order model
    @(negedge clk);
    resetn   = 1'b0;
    inv_mode = 1'b1;
    issued_q.delete();
    m_last = RESET_PC - 32'd4;
    m_pend = 1'b0;
    m_tgt  = 32'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      logic        ds, st, tk, full, exp_en;
      logic [31:0] tg, exp_addr, want;
      @(negedge clk);
      if (i == 0) resetn = 1'b1;
      ds = ($urandom % 4) != 0;
      st = ($urandom % 8) == 0;
      tk = !m_pend && (($urandom % 6) == 0);
      tg = (($urandom % 10) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
      ds_allowin = ds;
      br_stall   = st;
      br_taken   = tk;
      br_target  = tg;
      #4;
      full     = issued_q.size() != 0;
      exp_en   = (!full || ds) && !st;
      exp_addr = m_pend ? m_tgt : (tk ? tg : m_last + 32'd4);
      chk("rnd_en", {63'h0, inst_sram_en}, {63'h0, exp_en});
      if (exp_en) chk("rnd_addr", {32'h0, inst_sram_addr}, {32'h0, exp_addr});
      chk("rnd_valid", {63'h0, fs_to_ds_valid}, {63'h0, full});
      if (full && ds) begin
        want = issued_q.pop_front();
        chk("rnd_deliver", fs_to_ds_bus, {inst_of(want), want});
      end
      if (exp_en) begin
        issued_q.push_back(exp_addr);
        m_last = exp_addr;
        m_pend = 1'b0;
      end else if (tk && !st && !m_pend) begin
        m_pend = 1'b1;
        m_tgt  = tg;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
